// File: rtl/oram_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one oram_module between N_REQ requesters.
// One ORAM operation is outstanding at a time; results return to the granted port.
module oram_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int D       = 8,
   parameter int A       = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0]       req_rw,
   input  logic [N_REQ*D-1:0]     req_block,
   input  logic [N_REQ*8*A-1:0]   req_wdata,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [8*A-1:0]         resp_rdata,
   output logic                   resp_err,
   output logic [D-1:0]           oram_rw_block_number,
   output logic [8*A-1:0]         oram_w_value,
   output logic                   oram_rw_indicator,
   output logic                   oram_input_ready,
   input  logic [8*A-1:0]         oram_r_value,
   input  logic                   oram_output_ready,
   output logic                   busy
);
   localparam int W  = 8 * A;
   localparam int PW = $clog2(N_REQ);
   localparam int CW = 8;
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [PW-1:0] LAST_C    = PW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, gnt_q, gidx;
   logic             found;
   logic [N_REQ-1:0] grant_oh;
   logic             rw_q;
   logic [D-1:0]     blk_q;
   logic [W-1:0]     wdata_q, rdata_q;
   logic             err_q;
   logic [CW-1:0]    cnt_q, cnt_inc;
   logic [D-1:0]     blk_arr [N_REQ];
   logic [W-1:0]     wd_arr  [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign blk_arr[i] = req_block[i*D +: D];
      assign wd_arr[i]  = req_wdata[i*W +: W];
   end

   // First requester at or after the pointer, wrapping modulo N_REQ.
   always_comb begin : arb
      int idx;
      found = 1'b0;
      gidx  = '0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            gidx  = PW'(idx);
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) grant_oh[i] = found && (gidx == PW'(i));
   end

   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (oram_output_ready || cnt_inc == TIMEOUT_C) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // req_ready is combinational from req_valid, so it is masked while rst is high.
   always_comb begin
      req_ready        = '0;
      resp_valid       = '0;
      oram_input_ready = (state_q == ISSUE);
      busy             = (state_q != IDLE);
      if (state_q == IDLE && !rst) req_ready = grant_oh;
      for (int i = 0; i < N_REQ; i++)
         resp_valid[i] = (state_q == RESP) && (gnt_q == PW'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         gnt_q   <= '0;
         rw_q    <= 1'b0;
         blk_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (found) begin
               gnt_q   <= gidx;
               rw_q    <= req_rw[gidx];
               blk_q   <= blk_arr[gidx];
               wdata_q <= wd_arr[gidx];
            end
            ISSUE: cnt_q <= '0;
            WAIT: begin
               // Completion wins over timeout when both land on the same cycle.
               if (oram_output_ready) begin
                  rdata_q <= rw_q ? '0 : oram_r_value;
                  err_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == TIMEOUT_C) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            RESP: ptr_q <= (gnt_q == LAST_C) ? '0 : gnt_q + PW'(1);
            default: ;
         endcase
      end
   end

   assign oram_rw_block_number = blk_q;
   assign oram_w_value         = wdata_q;
   assign oram_rw_indicator    = rw_q;
   assign resp_rdata           = rdata_q;
   assign resp_err             = err_q;

endmodule

// File: tb/tb_oram_req_arbiter.sv
// Directed bench for oram_req_arbiter with a small behavioural ORAM stub
// (configurable latency, stall for timeouts, write-back memory).
module tb_oram_req_arbiter;
   localparam int N  = 4;
   localparam int D  = 8;
   localparam int A  = 4;
   localparam int W  = 32;
   localparam int TO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid, req_ready, req_rw, resp_valid;
   logic [N*D-1:0]   req_block;
   logic [N*W-1:0]   req_wdata;
   logic [W-1:0]     resp_rdata;
   logic             resp_err;
   logic [D-1:0]     oram_blk;
   logic [W-1:0]     oram_w, oram_r;
   logic             oram_rw, oram_ir, oram_or, busy;

   int               n_assert = 0;
   int               n_fail   = 0;
   logic             stall;
   int               lat;
   int               left;
   logic [W-1:0]     pend;
   logic [W-1:0]     mem [256];
   logic [255:0]     wr_valid;
   logic [3:0]       rr_exp [5];

   always #5 clk = ~clk;

   oram_req_arbiter #(.N_REQ(N), .D(D), .A(A), .TIMEOUT(TO)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_rw               (req_rw),
      .req_block            (req_block),
      .req_wdata            (req_wdata),
      .resp_valid           (resp_valid),
      .resp_rdata           (resp_rdata),
      .resp_err             (resp_err),
      .oram_rw_block_number (oram_blk),
      .oram_w_value         (oram_w),
      .oram_rw_indicator    (oram_rw),
      .oram_input_ready     (oram_ir),
      .oram_r_value         (oram_r),
      .oram_output_ready    (oram_or),
      .busy                 (busy)
   );

   // Unwritten blocks read back as 0x1000_0000 + block number.
   function automatic logic [W-1:0] stub_rd(input logic [7:0] b);
      return wr_valid[b] ? mem[b] : (32'h1000_0000 | {24'h0, b});
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         oram_or  <= 1'b1;
         oram_r   <= '0;
         left     <= 0;
         pend     <= '0;
         wr_valid <= '0;
      end else if (oram_ir) begin
         if (oram_rw) begin
            mem[oram_blk]      <= oram_w;
            wr_valid[oram_blk] <= 1'b1;
         end
         if (stall) oram_or <= 1'b0;
         else if (lat == 0) begin
            oram_or <= 1'b1;
            oram_r  <= oram_rw ? '0 : stub_rd(oram_blk);
         end else begin
            oram_or <= 1'b0;
            left    <= lat;
            pend    <= oram_rw ? '0 : stub_rd(oram_blk);
         end
      end else if (left > 0) begin
         left <= left - 1;
         if (left == 1) begin
            oram_or <= 1'b1;
            oram_r  <= pend;
         end
      end else if (!stall) oram_or <= 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int p, input logic rw, input logic [7:0] blk, input logic [31:0] wd);
      req_rw[p]            = rw;
      req_block[p*D +: D]  = blk;
      req_wdata[p*W +: W]  = wd;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; lat = 0;
      req_rw = '0; req_block = '0; req_wdata = '0;
      req_valid = 4'b0010;
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_oram_ir", oram_ir, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_oram_blk", oram_blk, 0);
      req_valid = '0;
      cyc(); cyc();
      rst = 1'b0;

      // Single read on port 1
      set_req(1, 1'b0, 8'h05, 32'h0);
      req_valid = 4'b0010; #1;
      chk("t1_ready", req_ready, 4'b0010);
      chk("t1_idle_busy", busy, 0);
      cyc(); req_valid = '0;
      chk("t1_issue_ir", oram_ir, 1);
      chk("t1_issue_blk", oram_blk, 8'h05);
      chk("t1_issue_rw", oram_rw, 0);
      chk("t1_issue_ready", req_ready, 0);
      chk("t1_issue_busy", busy, 1);
      cyc();
      chk("t1_wait_ir", oram_ir, 0);
      chk("t1_wait_rv", resp_valid, 0);
      cyc();
      chk("t1_resp_valid", resp_valid, 4'b0010);
      chk("t1_resp_rdata", resp_rdata, 32'h1000_0005);
      chk("t1_resp_err", resp_err, 0);
      cyc();
      chk("t1_idle_rv", resp_valid, 0);
      chk("t1_rdata_hold", resp_rdata, 32'h1000_0005);
      chk("t1_idle_busy2", busy, 0);
      chk("t1_blk_hold", oram_blk, 8'h05);

      // Write then read on port 0 (pointer is 2, search wraps to 0)
      set_req(0, 1'b1, 8'h12, 32'hDEAD_BEEF);
      req_valid = 4'b0001; #1;
      chk("t2w_ready", req_ready, 4'b0001);
      cyc(); req_valid = '0;
      chk("t2w_wvalue", oram_w, 32'hDEAD_BEEF);
      chk("t2w_rw", oram_rw, 1);
      chk("t2w_blk", oram_blk, 8'h12);
      cyc(); cyc();
      chk("t2w_resp_valid", resp_valid, 4'b0001);
      chk("t2w_resp_rdata", resp_rdata, 0);
      cyc();
      set_req(0, 1'b0, 8'h12, 32'h0);
      req_valid = 4'b0001; #1;
      chk("t2r_ready", req_ready, 4'b0001);
      cyc(); req_valid = '0;
      cyc(); cyc();
      chk("t2r_resp_valid", resp_valid, 4'b0001);
      chk("t2r_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      cyc();

      // Round-robin with all ports held high from reset
      rst = 1'b1; req_valid = 4'b1111; #1;
      chk("t3_rst_ready", req_ready, 0);
      cyc(); cyc();
      rst = 1'b0; #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t3_grant%0d", k), req_ready, rr_exp[k]);
         cyc();
         chk($sformatf("t3_issue_nogrant%0d", k), req_ready, 0);
         cyc(); cyc();
         chk($sformatf("t3_resp%0d", k), resp_valid, rr_exp[k]);
         cyc();
      end

      // Pointer is now 1; grant port 2 to move it to 3, then ports 3 and 1 compete
      set_req(1, 1'b0, 8'h03, 32'h0);
      set_req(3, 1'b0, 8'h09, 32'h0);
      req_valid = 4'b0100; #1;
      chk("t4_grant2", req_ready, 4'b0100);
      cyc();
      req_valid = 4'b1010; #1;
      chk("t4_busy_noaccept", req_ready, 0);
      cyc(); cyc(); cyc();
      chk("t4_grant3", req_ready, 4'b1000);
      cyc(); cyc(); cyc();
      chk("t4_resp3", resp_valid, 4'b1000);
      cyc();
      chk("t4_grant1_wrap", req_ready, 4'b0010);
      cyc(); req_valid = '0;
      cyc(); cyc();
      chk("t4_resp1", resp_valid, 4'b0010);
      chk("t4_resp1_rdata", resp_rdata, 32'h1000_0003);
      cyc();

      // Timeout: stub never completes, pointer is 2
      stall = 1'b1;
      set_req(2, 1'b0, 8'h07, 32'h0);
      req_valid = 4'b0100; #1;
      chk("t5_ready", req_ready, 4'b0100);
      cyc(); req_valid = '0;
      chk("t5_issue_ir", oram_ir, 1);
      cyc();
      for (int w = 0; w < TO; w++) begin
         chk($sformatf("t5_wait%0d_norsp", w), resp_valid, 0);
         cyc();
      end
      chk("t5_resp_valid", resp_valid, 4'b0100);
      chk("t5_resp_err", resp_err, 1);
      chk("t5_resp_rdata", resp_rdata, 0);
      stall = 1'b0;
      cyc();

      // Completion on the last WAIT cycle beats the timeout (pointer 3, wraps to 1)
      lat = 3;
      set_req(1, 1'b0, 8'h05, 32'h0);
      req_valid = 4'b0010; #1;
      chk("t6_ready", req_ready, 4'b0010);
      cyc(); req_valid = '0;
      cyc();
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("t6_wait%0d_norsp", w), resp_valid, 0);
         cyc();
      end
      cyc();
      chk("t6_resp_valid", resp_valid, 4'b0010);
      chk("t6_resp_err", resp_err, 0);
      chk("t6_resp_rdata", resp_rdata, 32'h1000_0005);
      cyc();

      // Reset in WAIT: pointer 2 grants port 3, then reset abandons it
      lat = 0;
      req_valid = 4'b1000; #1;
      chk("t7_ready", req_ready, 4'b1000);
      cyc(); req_valid = '0;
      cyc();
      chk("t7_wait_busy", busy, 1);
      rst = 1'b1; #1;
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_ir", oram_ir, 0);
      chk("t7_rst_rv", resp_valid, 0);
      chk("t7_rst_rdata", resp_rdata, 0);
      chk("t7_rst_err", resp_err, 0);
      chk("t7_rst_blk", oram_blk, 0);
      chk("t7_rst_wval", oram_w, 0);
      cyc();
      chk("t7_rst_norsp_a", resp_valid, 0);
      cyc();
      chk("t7_rst_norsp_b", resp_valid, 0);
      rst = 1'b0;
      set_req(1, 1'b0, 8'h03, 32'h0);
      req_valid = 4'b1010; #1;
      chk("t7_ptr0_grant", req_ready, 4'b0010);
      cyc(); req_valid = '0;
      cyc(); cyc();
      chk("t7_resp_valid", resp_valid, 4'b0010);
      chk("t7_resp_rdata", resp_rdata, 32'h1000_0003);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
